hazard_controller: RTL

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_pkg.sv | 33 +++
 rtl/hazard_fwd_unit.sv | 34 +++
 rtl/hazard_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned FWD_W   = 2;
    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_e;

    // Operand forward selects, youngest producer wins
    localparam logic [FWD_W-1:0] FWD_RF  = 2'd0;
    localparam logic [FWD_W-1:0] FWD_EX  = 2'd1;
    localparam logic [FWD_W-1:0] FWD_MEM = 2'd2;
    localparam logic [FWD_W-1:0] FWD_WB  = 2'd3;

    // MEM_WAIT cycles tolerated before declaring a memory timeout
    localparam logic [WAIT_W-1:0] MEM_TIMEOUT = 8'd255;

    // Pipeline register load enables, IF side first
    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } pipe_en_t;

endpackage

// File: rtl/hazard_fwd_unit.sv
// Forward-select decode for one ID-stage source operand.
// Ports: rs/rs_used - source register and whether it is read;
//        ex/mem/wb destination and write-enable per stage, ex_load;
//        fwd_sel - FWD_EX/FWD_MEM/FWD_WB or FWD_RF when no producer in flight.
module hazard_fwd_unit
    import hazard_pkg::*;
(
    input  logic [REG_W-1:0] rs,
    input  logic             rs_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_we,
    input  logic             ex_load,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_we,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_we,
    output logic [FWD_W-1:0] fwd_sel
);

    // A load in EX has no data yet; that case is handled by the load-use stall
    always_comb begin
        fwd_sel = FWD_RF;
        if (rs_used && (rs != '0)) begin
            if (ex_we && !ex_load && (rs == ex_rd)) begin
                fwd_sel = FWD_EX;
            end else if (mem_we && (rs == mem_rd)) begin
                fwd_sel = FWD_MEM;
            end else if (wb_we && (rs == wb_rd)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush,
// data-memory wait stalls with timeout, operand forwarding, stall counter.
// Ports: clk, reset_n (async active-low);
//        ID sources id_rs1/2 + id_use1/2; EX/MEM/WB rd + we, ex_load;
//        ex_branch_taken; mem_req/mem_ack;
//        nop_signal, ifid_clr, pc/ifid/idex/exmem/memwb load enables,
//        fwd_a/fwd_b, mem_timeout (sticky), stall_cnt (saturating).
// Control outputs are decoded from state plus current inputs.
module hazard_controller
    import hazard_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [REG_W-1:0]   id_rs1,
    input  logic [REG_W-1:0]   id_rs2,
    input  logic               id_use1,
    input  logic               id_use2,
    input  logic [REG_W-1:0]   ex_rd,
    input  logic [REG_W-1:0]   mem_rd,
    input  logic [REG_W-1:0]   wb_rd,
    input  logic               ex_we,
    input  logic               mem_we,
    input  logic               wb_we,
    input  logic               ex_load,
    input  logic               ex_branch_taken,
    input  logic               mem_req,
    input  logic               mem_ack,
    output logic               nop_signal,
    output logic               pc_le,
    output logic               ifid_le,
    output logic               idex_le,
    output logic               exmem_le,
    output logic               memwb_le,
    output logic               ifid_clr,
    output logic [FWD_W-1:0]   fwd_a,
    output logic [FWD_W-1:0]   fwd_b,
    output logic               mem_timeout,
    output logic [STALL_W-1:0] stall_cnt
);

    state_e              state_q, state_nxt;
    logic [WAIT_W-1:0]   wait_q, wait_nxt, wait_inc;
    logic [STALL_W-1:0]  stall_q;
    logic [FWD_W-1:0]    fwd_a_raw, fwd_b_raw;
    logic                load_use;
    logic                freeze;
    logic                apply_rules;
    pipe_en_t            en;

    hazard_fwd_unit u_fwd_a (
        .rs      (id_rs1),
        .rs_used (id_use1),
        .ex_rd   (ex_rd),
        .ex_we   (ex_we),
        .ex_load (ex_load),
        .mem_rd  (mem_rd),
        .mem_we  (mem_we),
        .wb_rd   (wb_rd),
        .wb_we   (wb_we),
        .fwd_sel (fwd_a_raw)
    );

    hazard_fwd_unit u_fwd_b (
        .rs      (id_rs2),
        .rs_used (id_use2),
        .ex_rd   (ex_rd),
        .ex_we   (ex_we),
        .ex_load (ex_load),
        .mem_rd  (mem_rd),
        .mem_we  (mem_we),
        .wb_rd   (wb_rd),
        .wb_we   (wb_we),
        .fwd_sel (fwd_b_raw)
    );

    // Inputs are ignored while reset is held
    assign fwd_a = reset_n ? fwd_a_raw : FWD_RF;
    assign fwd_b = reset_n ? fwd_b_raw : FWD_RF;

    // Load in EX feeding a used, non-zero ID source
    assign load_use = ex_load && ex_we && (ex_rd != '0) &&
                      ((id_use1 && (id_rs1 == ex_rd)) ||
                       (id_use2 && (id_rs2 == ex_rd)));

    assign wait_inc = wait_q + WAIT_W'(1);

    // Next-state and control decode
    always_comb begin
        state_nxt   = state_q;
        wait_nxt    = wait_q;
        freeze      = 1'b0;
        apply_rules = 1'b0;
        mem_timeout = 1'b0;
        nop_signal  = 1'b0;
        ifid_clr    = 1'b0;
        en          = '1;

        if (reset_n) begin
            case (state_q)
                RUN: begin
                    // The request cycle itself stalls when memory is not ready
                    if (mem_req && !mem_ack) begin
                        state_nxt = MEM_WAIT;
                        wait_nxt  = '0;
                        freeze    = 1'b1;
                    end else begin
                        apply_rules = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (mem_ack) begin
                        state_nxt   = RUN;
                        apply_rules = 1'b1;
                    end else begin
                        freeze   = 1'b1;
                        wait_nxt = wait_inc;
                        if (wait_inc == MEM_TIMEOUT) begin
                            state_nxt = ERROR;
                        end
                    end
                end
                ERROR: begin
                    freeze      = 1'b1;
                    mem_timeout = 1'b1;
                end
                default: begin
                    state_nxt = RUN;
                end
            endcase

            // Frozen EX makes a branch or load seen now stale; they are re-presented later
            if (freeze) begin
                en = '0;
            end else if (apply_rules) begin
                if (ex_branch_taken) begin
                    ifid_clr   = 1'b1;
                    nop_signal = 1'b1;
                end else if (load_use) begin
                    nop_signal = 1'b1;
                    en.pc      = 1'b0;
                    en.ifid    = 1'b0;
                end
            end
        end
    end

    assign pc_le    = en.pc;
    assign ifid_le  = en.ifid;
    assign idex_le  = en.idex;
    assign exmem_le = en.exmem;
    assign memwb_le = en.memwb;
    assign stall_cnt = stall_q;

    // State, wait counter and saturating stall counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_nxt;
            wait_q  <= wait_nxt;
            if (!en.pc && (stall_q != '1)) begin
                stall_q <= stall_q + STALL_W'(1);
            end
        end
    end

endmodule
